// File: rtl/mux_gate_pkg.sv
// Shared definitions for the bit-serial gate evaluator: op codes, FSM states,
// XOR step encoding and the mux drive bundle.
package mux_gate_pkg;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    S_NA = 3'd0,
    S_NB = 3'd1,
    S_W1 = 3'd2,
    S_W2 = 3'd3,
    S_Y  = 3'd4
  } xor_step_t;

  // One complete set of inputs for the shared 2:1 mux.
  typedef struct packed {
    logic in0;
    logic in1;
    logic sel;
  } mux_drive_t;

  // XOR is built from NOT/AND/OR sub-steps; the other ops need one mux pass.
  function automatic logic [2:0] steps_for_op(input logic [1:0] op_code);
    return (op_code == OP_XOR) ? 3'd5 : 3'd1;
  endfunction

endpackage

// File: rtl/mux_gate_sequencer_mux2to1.sv
// The single shared 2:1 multiplexer primitive; every gate result passes through it.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_gate_sequencer.sv
// Bit-serial NOT/AND/OR/XOR evaluator that time-shares one 2:1 mux, LSB first,
// one mux evaluation per clock, behind valid/ready request and result handshakes.
module mux_gate_sequencer
  import mux_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_reg,   state_next;
  logic [1:0]       op_reg,      op_next;
  logic [WIDTH-1:0] a_reg,       a_next;
  logic [WIDTH-1:0] b_reg,       b_next;
  logic [WIDTH-1:0] result_reg,  result_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic [2:0]       step_reg,    step_next;
  logic             na_reg,      na_next;
  logic             nb_reg,      nb_next;
  logic             w1_reg,      w1_next;
  logic             w2_reg,      w2_next;

  mux_drive_t drive;
  logic       mux_y;
  logic       bit_a;
  logic       bit_b;
  logic       step_last;
  logic       bit_last;

  assign bit_a     = a_reg[bit_idx_reg];
  assign bit_b     = b_reg[bit_idx_reg];
  assign step_last = (step_reg == (steps_for_op(op_reg) - 3'd1));
  assign bit_last  = (bit_idx_reg == LAST_IDX);

  // Route the mux inputs for the current op/step; constants 0/1 act as gate identities.
  always_comb begin
    drive = '0;
    unique case (op_reg)
      OP_NOT: drive = '{in0: 1'b1, in1: 1'b0,  sel: bit_a};
      OP_AND: drive = '{in0: 1'b0, in1: bit_b, sel: bit_a};
      OP_OR:  drive = '{in0: bit_b, in1: 1'b1, sel: bit_a};
      OP_XOR: begin
        unique case (step_reg)
          S_NA:    drive = '{in0: 1'b1,   in1: 1'b0,   sel: bit_a};
          S_NB:    drive = '{in0: 1'b1,   in1: 1'b0,   sel: bit_b};
          S_W1:    drive = '{in0: 1'b0,   in1: bit_b,  sel: na_reg};
          S_W2:    drive = '{in0: 1'b0,   in1: nb_reg, sel: bit_a};
          S_Y:     drive = '{in0: w2_reg, in1: 1'b1,   sel: w1_reg};
          default: drive = '0;
        endcase
      end
      default: drive = '0;
    endcase
  end

  mux2to1 u_mux (
    .a   (drive.in0),
    .b   (drive.in1),
    .sel (drive.sel),
    .y   (mux_y)
  );

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    result_next  = result_reg;
    bit_idx_next = bit_idx_reg;
    step_next    = step_reg;
    na_next      = na_reg;
    nb_next      = nb_reg;
    w1_next      = w1_reg;
    w2_next      = w2_reg;

    unique case (state_reg)
      IDLE: begin
        if (start_valid) begin
          op_next      = op;
          a_next       = a;
          b_next       = b;
          result_next  = '0;
          bit_idx_next = '0;
          step_next    = '0;
          state_next   = EVAL;
        end
      end

      EVAL: begin
        // XOR intermediate steps land in the per-bit scratch registers.
        if (op_reg == OP_XOR) begin
          unique case (step_reg)
            S_NA:    na_next = mux_y;
            S_NB:    nb_next = mux_y;
            S_W1:    w1_next = mux_y;
            S_W2:    w2_next = mux_y;
            default: ;
          endcase
        end
        if (step_last) begin
          result_next[bit_idx_reg] = mux_y;
          step_next                = '0;
          if (bit_last) begin
            state_next = DONE;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else begin
          step_next = step_reg + 3'd1;
        end
      end

      DONE: begin
        if (result_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op_reg      <= OP_NOT;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      bit_idx_reg <= '0;
      step_reg    <= '0;
      na_reg      <= 1'b0;
      nb_reg      <= 1'b0;
      w1_reg      <= 1'b0;
      w2_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      result_reg  <= result_next;
      bit_idx_reg <= bit_idx_next;
      step_reg    <= step_next;
      na_reg      <= na_next;
      nb_reg      <= nb_next;
      w1_reg      <= w1_next;
      w2_reg      <= w2_next;
    end
  end

  // Handshake outputs depend only on registered state.
  assign start_ready  = (state_reg == IDLE);
  assign busy         = (state_reg == EVAL) || (state_reg == DONE);
  assign result_valid = (state_reg == DONE);
  assign result       = result_reg;

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Directed plus randomized bench for mux_gate_sequencer against a word-level gate model.
module tb_mux_gate_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mux_gate_sequencer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (req_op),
    .a            (req_a),
    .b            (req_b),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  function automatic logic [WIDTH-1:0] ref_gate(input logic [1:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (o)
      2'b00:   return ~x;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic int ref_steps(input logic [1:0] o);
    return (o == 2'b11) ? 5 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after the accept edge; follows progress until result_valid.
  task automatic wait_result(input logic [1:0] o, input logic [WIDTH-1:0] expv, input string tag);
    int cyc = 0;
    int steps = ref_steps(o);
    int done_bits;
    logic [WIDTH-1:0] mask;
    while (result_valid !== 1'b1 && cyc < 400) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_sready_low"}, 32'(start_ready), 32'd0);
      done_bits = cyc / steps;
      mask = WIDTH'((64'd1 << done_bits) - 64'd1);
      check({tag, "_partial"}, 32'(result), 32'(expv & mask));
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_valid"}, 32'(result_valid), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH * steps));
    check({tag, "_result"}, 32'(result), 32'(expv));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input int hold, input string tag);
    logic [WIDTH-1:0] expv;
    expv = ref_gate(o, x, y);
    @(negedge clk);
    check({tag, "_sready"}, 32'(start_ready), 32'd1);
    req_op = o; req_a = x; req_b = y; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    req_a = WIDTH'($urandom); req_b = WIDTH'($urandom); req_op = 2'($urandom);
    wait_result(o, expv, tag);
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(result), 32'(expv));
      check({tag, "_hold_sready"}, 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_post_sready"}, 32'(start_ready), 32'd1);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
    $display("txn %s op=%0d a=%h b=%h exp=%h got=%h", tag, o, x, y, expv, result);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [1:0]       ro;

    rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    req_op = 2'b00; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(2'b11, 8'hA5, 8'h0F, 0, "xor_a5_0f");
    run_op(2'b01, 8'hF0, 8'h3C, 0, "and_f0_3c");
    run_op(2'b10, 8'h81, 8'h18, 5, "or_backpressure");
    run_op(2'b00, 8'h5A, 8'hFF, 1, "not_5a");

    // Reset in the middle of an XOR evaluation.
    @(negedge clk);
    req_op = 2'b11; req_a = 8'h3C; req_b = 8'hC3; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_sready", 32'(start_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_hold_valid", 32'(result_valid), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_valid", 32'(result_valid), 32'd0);
    $display("txn reset_mid_xor aborted");
    run_op(2'b01, 8'hFF, 8'h01, 0, "and_after_rst");

    // start_valid held across two XOR requests.
    @(negedge clk);
    req_op = 2'b11; req_a = 8'h3C; req_b = 8'h96; start_valid = 1'b1; result_ready = 1'b1;
    @(posedge clk); #1;
    req_a = 8'h12; req_b = 8'hE7;
    wait_result(2'b11, ref_gate(2'b11, 8'h3C, 8'h96), "b2b_first");
    @(posedge clk); #1;
    check("b2b_gap_valid", 32'(result_valid), 32'd0);
    check("b2b_gap_sready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_second_accept", 32'(busy), 32'd1);
    start_valid = 1'b0; result_ready = 1'b0;
    wait_result(2'b11, ref_gate(2'b11, 8'h12, 8'hE7), "b2b_second");
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("b2b_end_sready", 32'(start_ready), 32'd1);
    $display("txn b2b_xor first=%h second=%h", ref_gate(2'b11, 8'h3C, 8'h96),
             ref_gate(2'b11, 8'h12, 8'hE7));

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op(ro, ra, rb, $urandom_range(0, 3), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
